// File: rtl/video_timing_gen.sv
// Pixel timing generator: waits for a qualified PLL lock, then sweeps (h,v) and
// produces registered sync, data-enable, coordinate and frame-start outputs.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE  = 1600,
  parameter int unsigned H_FP      = 64,
  parameter int unsigned H_SYNC    = 192,
  parameter int unsigned H_BP      = 304,
  parameter int unsigned V_ACTIVE  = 1200,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_BP      = 46,
  parameter bit          HS_POL    = 1'b1,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned LOCK_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lock,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]  LW     = 8'(LOCK_WAIT);

  if (H_TOTAL > 4096) begin : g_h_width_err
    $error("H_TOTAL-1 does not fit the 12-bit horizontal counter");
  end
  if (V_TOTAL > 2048) begin : g_v_width_err
    $error("V_TOTAL-1 does not fit the 11-bit vertical counter");
  end
  if (LOCK_WAIT < 1 || LOCK_WAIT > 255) begin : g_lock_wait_err
    $error("LOCK_WAIT must lie in 1..255");
  end

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t      state_q, state_d;
  logic        lock_meta_q, lock_s_q;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        fs_q, fs_d;
  logic        running_q, running_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      lock_cnt_q  <= '0;
      state_q     <= S_WAIT;
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fs_q        <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
      lock_cnt_q  <= lock_cnt_d;
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fs_q        <= fs_d;
      running_q   <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;

    if (!lock_s_q)              lock_cnt_d = '0;
    else if (lock_cnt_q == LW)  lock_cnt_d = lock_cnt_q;
    else                        lock_cnt_d = lock_cnt_q + 8'd1;

    case (state_q)
      S_WAIT: begin
        h_d = '0;
        v_d = '0;
        if (lock_cnt_q == LW) state_d = S_RUN;
      end
      S_RUN: begin
        // Counters return to the origin on lock loss so a relock starts at (0,0).
        if (!lock_s_q) begin
          state_d = S_WAIT;
          h_d     = '0;
          v_d     = '0;
        end else if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
        end else begin
          h_d = h_q + 12'd1;
        end
      end
      default: state_d = S_WAIT;
    endcase

    running_d = (state_d == S_RUN);

    hsync_d = ~HS_POL;
    vsync_d = ~VS_POL;
    de_d    = 1'b0;
    x_d     = '0;
    y_d     = '0;
    fs_d    = 1'b0;
    // Outputs are decoded from the current counter, hence one clock behind it.
    if (state_q == S_RUN) begin
      de_d    = (h_q < H_ACT) && (v_q < V_ACT);
      hsync_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
      x_d     = h_q;
      y_d     = v_q;
      fs_d    = (h_q == '0) && (v_q == '0);
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign running     = running_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced 32x14 raster so whole
// frames fit in a short run; expected values are hand-derived from that raster.
module tb_video_timing_gen;

  logic        clk;
  logic        rst_n;
  logic        lock;
  logic        hsync, vsync, de, frame_start, running;
  logic [11:0] x;
  logic [10:0] y;

  int unsigned n_vec;
  int unsigned n_err;

  // Raster: H 16+4+6+6 = 32, V 8+1+2+3 = 14, frame 448 clocks.
  video_timing_gen #(
    .H_ACTIVE (16),
    .H_FP     (4),
    .H_SYNC   (6),
    .H_BP     (6),
    .V_ACTIVE (8),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (3),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1),
    .LOCK_WAIT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lock       (lock),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // {running, de, frame_start, hsync, vsync, x, y}
  function automatic logic [31:0] snap();
    return {4'b0, running, de, frame_start, hsync, vsync, x, y};
  endfunction

  function automatic logic [31:0] pack(input logic r, input logic d, input logic f,
                                       input logic hs, input logic vs,
                                       input logic [11:0] px, input logic [10:0] py);
    return {4'b0, r, d, f, hs, vs, px, py};
  endfunction

  localparam logic [31:0] IDLE = 32'h0;

  initial begin
    int unsigned cyc;
    int unsigned eh, ev;
    int unsigned de_cnt, hs_cnt, vs_cnt, fs_first, fs_second, fs_seen;
    logic        found;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    lock  = 1'b0;

    #3;
    check("reset_idle", snap(), IDLE);

    // Startup: lock high from reset release; running expected on the 19th edge.
    @(negedge clk);
    rst_n = 1'b1;
    lock  = 1'b1;
    cyc = 0;
    while (!running && cyc < 60) begin
      tick();
      cyc++;
    end
    check("startup_latency", cyc, 19);
    check("startup_outputs_still_idle", {running, de, frame_start}, 3'b100);

    // Two full frames plus a bit, against an independent raster model.
    eh = 0; ev = 0;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_seen = 0; fs_first = 0; fs_second = 0;
    for (int unsigned i = 0; i < 2 * 448 + 40; i++) begin
      tick();
      check("raster", snap(),
            pack(1'b1, (eh < 16) && (ev < 8), (eh == 0) && (ev == 0),
                 (eh >= 20) && (eh < 26), (ev >= 9) && (ev < 11),
                 12'(eh), 11'(ev)));
      if (i < 32 && de)    de_cnt++;
      if (i < 32 && hsync) hs_cnt++;
      if (i < 448 && vsync) vs_cnt++;
      if (frame_start) begin
        if (fs_seen == 0) fs_first = i;
        else if (fs_seen == 1) fs_second = i;
        fs_seen++;
      end
      if (eh == 31) begin
        eh = 0;
        ev = (ev == 13) ? 0 : ev + 1;
      end else begin
        eh++;
      end
    end
    check("de_per_line", de_cnt, 16);
    check("hsync_per_line", hs_cnt, 6);
    check("vsync_per_frame", vs_cnt, 64);
    check("frame_start_count", fs_seen, 3);
    check("frame_start_first", fs_first, 0);
    check("frame_start_period", fs_second - fs_first, 448);

    // Lock glitch: one clock low mid-frame.
    lock = 1'b0;
    tick();
    lock = 1'b1;
    cyc = 0;
    while (running && cyc < 10) begin
      tick();
      cyc++;
    end
    check("glitch_drop_latency", cyc, 2);
    tick();
    cyc = 1;
    while (!running && cyc < 40) begin
      check("glitch_idle", snap(), IDLE);
      tick();
      cyc++;
    end
    check("relock_latency", cyc, 17);
    tick();
    check("relock_origin", snap(), pack(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 11'd0));

    // Short lock: 10 clocks high must never qualify.
    rst_n = 1'b0;
    lock  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    lock = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      check("short_lock_high", snap(), IDLE);
    end
    lock = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      tick();
      check("short_lock_low", snap(), IDLE);
    end

    // Async reset mid-line at (8,5), asserted between clock edges.
    lock = 1'b1;
    cyc = 0;
    while (!running && cyc < 40) begin
      tick();
      cyc++;
    end
    check("restart_running", running, 1'b1);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 600) begin
      tick();
      cyc++;
      found = (x == 12'd8) && (y == 11'd5);
    end
    check("reach_mid_line", found, 1'b1);
    check("mid_line_de", de, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_idle", snap(), IDLE);
    tick();
    check("reset_held_idle", snap(), IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1600: visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 64: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 192: hsync width, in clocks.
REQ-004 SHALL have parameter H_BP, default 304: horizontal back porch, in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 1200: visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 1: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 3: vsync width, in lines.
REQ-008 SHALL have parameter V_BP, default 46: vertical back porch, in lines.
REQ-009 SHALL have parameters HS_POL and VS_POL, default 1: active level of hsync and vsync.
REQ-010 SHALL have parameter LOCK_WAIT, default 16: stable-lock clocks required before start, range 1..255.
REQ-011 SHALL have port clk, input, 1 bit: 162 MHz pixel clock (PLL clkout); the only clock.
REQ-012 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-013 SHALL have port lock, input, 1 bit: PLL lock, asynchronous to clk.
REQ-014 SHALL have ports hsync and vsync, output, 1 bit each: sync pulses.
REQ-015 SHALL have port de, output, 1 bit: data enable, high in the active area.
REQ-016 SHALL have port x, output, 12 bits: horizontal counter value.
REQ-017 SHALL have port y, output, 11 bits: vertical counter value.
REQ-018 SHALL have port frame_start, output, 1 bit: one-clock pulse at position (0,0).
REQ-019 SHALL have port running, output, 1 bit: the timing generator is active.

Function
REQ-020 SHALL synchronise lock through two flops to produce lock_s.
REQ-021 SHALL count lock_s-high clocks in an 8-bit counter that saturates at LOCK_WAIT.
- A low lock_s clears the counter to 0.
REQ-022 SHALL use a two-state FSM:
- WAIT -> RUN when the lock counter equals LOCK_WAIT; running=1 in RUN.
- RUN -> WAIT on the first clock that lock_s=0; running=0 in WAIT.
REQ-023 SHALL hold h=0 and v=0 in WAIT.
REQ-024 SHALL, in RUN, increment h each clock and wrap it at H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; 2160 by default).
- v increments on each h wrap and wraps at V_TOTAL-1 (1250 by default).
REQ-025 SHALL register all outputs; x, y, de, hsync, vsync and frame_start are mutually aligned and reflect the same (h,v), one clock after the counter.
REQ-026 SHALL set de=1 iff h<H_ACTIVE and v<V_ACTIVE.
REQ-027 SHALL drive hsync to HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise to ~HS_POL.
REQ-028 SHALL drive vsync to VS_POL for whole lines iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; otherwise to ~VS_POL.
REQ-029 SHALL drive x=h and y=v over the full range, including blanking.
REQ-030 SHALL pulse frame_start for exactly one clock when (h,v)=(0,0) in RUN, including the first RUN clock after each start.
REQ-031 SHALL, in WAIT, drive outputs idle: de=0, frame_start=0, x=0, y=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-032 SHALL, on lock loss mid-frame, go idle one clock after the FSM leaves RUN, with no partial sync pulse extension.
- After relock the generator restarts at (0,0).
REQ-033 SHALL raise no width error with the defaults: H_TOTAL-1=2159 fits 12 bits and V_TOTAL-1=1249 fits 11 bits.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously clear the sync flops, lock counter, h, v and FSM (state WAIT).
- Outputs take the REQ-031 idle values with running=0.
REQ-035 SHALL resume on rst_n release and require the full LOCK_WAIT qualification again.

Verification
REQ-036 SHALL cover startup: lock=1 from reset release -> running rises 2+16 clocks later (±1); the first registered output is frame_start=1, de=1, x=0, y=0.
REQ-037 SHALL cover line timing: in RUN -> de high for 1600 clocks per line; hsync high exactly at x=1664..1855; line period 2160 clocks.
REQ-038 SHALL cover frame timing: vsync high for lines y=1201..1203 (3×2160 clocks); frame_start period exactly 2,700,000 clocks.
REQ-039 SHALL cover a lock glitch: lock low for 1 clock mid-frame -> running drops, outputs idle, restart at (0,0) after 16 stable clocks.
REQ-040 SHALL cover short lock: lock high for 10 clocks then low -> running never asserts and outputs stay idle.
REQ-041 SHALL cover async reset: rst_n low mid-line (x=800, y=600) -> all outputs idle immediately, without waiting for a clock edge.
